// File: rtl/jtcop_snd_pkg.sv
// Shared definitions for the HuC6280 sound bus: region indices in read-priority
// order, address decode bit positions and the idle read value.
package jtcop_snd_pkg;

  // Lower index wins when more than one region drives the read mux
  typedef enum logic [2:0] {
    RGN_RAM   = 3'd0,
    RGN_OPN   = 3'd1,
    RGN_OPL   = 3'd2,
    RGN_OKI   = 3'd3,
    RGN_LATCH = 3'd4,
    RGN_ROM   = 3'd5
  } rgn_e;

  localparam int NRGN = 6;

  localparam int A0_BIT  = 0;
  localparam int A13_BIT = 13;
  localparam int A15_BIT = 15;
  localparam int A16_BIT = 16;
  localparam int A17_BIT = 17;

  localparam logic [7:0] IDLE_RD = 8'hff;

  function automatic logic [NRGN-1:0] decode(input logic io, input logic [17:0] a);
    logic [NRGN-1:0] cs;
    cs            = '0;
    cs[RGN_ROM]   = !io;
    cs[RGN_OPL]   = io & !a[A16_BIT] & a[A15_BIT];
    cs[RGN_OPN]   = io &  a[A16_BIT] & a[A15_BIT];
    cs[RGN_OKI]   = io &  a[A17_BIT] & !a[A15_BIT] &  a[A0_BIT];
    cs[RGN_LATCH] = io &  a[A17_BIT] & !a[A15_BIT] & !a[A0_BIT];
    cs[RGN_RAM]   = io & !a[A17_BIT] & !a[A15_BIT] & !a[A13_BIT];
    return cs;
  endfunction

endpackage

// File: rtl/jtcop_snd_cmdfifo.sv
// Main-to-sound command channel. With JTCOP_SND_FIFO_EN defined it is a
// 2**FIFO_AW deep FIFO; otherwise it is the legacy single overwrite latch.
module jtcop_snd_cmdfifo #(
  parameter int FIFO_AW = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [7:0]       data_i,
  input  logic             pop_i,
  output logic [7:0]       head_o,
  output logic [FIFO_AW:0] lvl_o,
  output logic             ovf_o
);

`ifdef JTCOP_SND_FIFO_EN
  localparam int DEPTH = 2**FIFO_AW;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0]   lvl_q;
  logic [7:0]         last_q;
  logic               ovf_q;
  logic               full, empty, do_push, do_pop;

  assign full    = (lvl_q == (FIFO_AW+1)'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign do_pop  = pop_i & !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
  assign do_push = push_i & (!full | do_pop);

  // NOTE: storage has no reset; only the pointers and level qualify its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      last_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
      if (push_i & !do_push) ovf_q <= 1'b1;
    end
  end

  assign head_o = empty ? last_q : mem_q[rd_q];
  assign lvl_o  = lvl_q;
  assign ovf_o  = ovf_q;
`else
  logic [7:0] data_q;
  logic       pend_q;
  logic       ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 8'h00;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_i) data_q <= data_i;
      if (push_i)     pend_q <= 1'b1;
      else if (pop_i) pend_q <= 1'b0;
      if (push_i & pend_q & !pop_i) ovf_q <= 1'b1;
    end
  end

  assign head_o = data_q;
  assign lvl_o  = {{FIFO_AW{1'b0}}, pend_q};
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: rtl/jtcop_snd_bus.sv
// HuC6280 sound CPU bus controller: select latching, ROM wait/timeout, read
// mux and command channel. Define JTCOP_SND_FIFO_EN for the command FIFO.
module jtcop_snd_bus
  import jtcop_snd_pkg::*;
#(
  parameter int AW      = 21,
  parameter int FIFO_AW = 2,
  parameter int TOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    cpu_a,
  input  logic             cpu_sx,
  input  logic             cpu_ce,
  input  logic             cpu_wrn,
  output logic [7:0]       cpu_din,
  output logic             cpu_waitn,
  output logic             cmd_irqn,
  output logic             rom_cs,
  output logic             ram_cs,
  output logic             opl_cs,
  output logic             opn_cs,
  output logic             oki_cs,
  output logic             latch_cs,
  input  logic [7:0]       rom_data,
  input  logic             rom_ok,
  input  logic [7:0]       ram_dout,
  input  logic [7:0]       opl_dout,
  input  logic [7:0]       opn_dout,
  input  logic [7:0]       oki_dout,
  input  logic             snreq,
  input  logic [7:0]       latch,
  output logic [FIFO_AW:0] fifo_lvl,
  output logic             ovf,
  output logic             tout_err
);

  localparam int CW = $clog2(TOUT + 1);

  logic [NRGN-1:0] cs_d, cs_q;
  logic [7:0]      din_d, din_q;
  logic [CW-1:0]   wcnt_d, wcnt_q;
  logic            waitn_d, waitn_q;
  logic            timed_out_d, timed_out_q;
  logic            tout_err_d, tout_err_q;
  logic            irqn_d, irqn_q;
  logic            snreq_q;
  logic            waiting, tout_hit, cmd_push, cmd_pop;
  logic [7:0]      cmd_head;
  logic [7:0]      src [NRGN];

  assign waiting  = cs_q[RGN_ROM] & !rom_ok & !timed_out_q;
  assign tout_hit = waiting & (wcnt_q == CW'(TOUT));
  assign cmd_push = snreq & !snreq_q;
  assign cmd_pop  = cpu_ce & cs_q[RGN_LATCH] & cpu_wrn;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cs_d = cs_q;
    if (cpu_sx)      cs_d = decode(cpu_a[AW-1], cpu_a[17:0]);
    else if (cpu_ce) cs_d = '0;

    src[RGN_RAM]   = ram_dout;
    src[RGN_OPN]   = opn_dout;
    src[RGN_OPL]   = opl_dout;
    src[RGN_OKI]   = oki_dout;
    src[RGN_LATCH] = cmd_head;
    src[RGN_ROM]   = (timed_out_q | tout_hit) ? IDLE_RD : rom_data;

    // Walk from lowest to highest priority so the last hit wins
    din_d = IDLE_RD;
    for (int i = NRGN - 1; i >= 0; i--) begin
      if (cs_q[i]) din_d = src[i];
    end

    wcnt_d = wcnt_q;
    if (cpu_sx)                    wcnt_d = '0;
    else if (waiting && !tout_hit) wcnt_d = wcnt_q + 1'b1;

    timed_out_d = timed_out_q;
    if (cpu_sx)              timed_out_d = 1'b0;
    else if (tout_hit)       timed_out_d = 1'b1;
    else if (!cs_q[RGN_ROM]) timed_out_d = 1'b0;

    waitn_d    = !(waiting & !tout_hit);
    tout_err_d = tout_err_q | tout_hit;
    irqn_d     = (fifo_lvl == '0);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q        <= '0;
      din_q       <= IDLE_RD;
      wcnt_q      <= '0;
      waitn_q     <= 1'b1;
      timed_out_q <= 1'b0;
      tout_err_q  <= 1'b0;
      irqn_q      <= 1'b1;
      snreq_q     <= 1'b0;
    end else begin
      cs_q        <= cs_d;
      din_q       <= din_d;
      wcnt_q      <= wcnt_d;
      waitn_q     <= waitn_d;
      timed_out_q <= timed_out_d;
      tout_err_q  <= tout_err_d;
      irqn_q      <= irqn_d;
      snreq_q     <= snreq;
    end
  end

  jtcop_snd_cmdfifo #(.FIFO_AW(FIFO_AW)) u_cmd (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (cmd_push),
    .data_i (latch),
    .pop_i  (cmd_pop),
    .head_o (cmd_head),
    .lvl_o  (fifo_lvl),
    .ovf_o  (ovf)
  );

  assign cpu_din   = din_q;
  assign cpu_waitn = waitn_q;
  assign cmd_irqn  = irqn_q;
  assign tout_err  = tout_err_q;
  assign rom_cs    = cs_q[RGN_ROM];
  assign ram_cs    = cs_q[RGN_RAM];
  assign opl_cs    = cs_q[RGN_OPL];
  assign opn_cs    = cs_q[RGN_OPN];
  assign oki_cs    = cs_q[RGN_OKI];
  assign latch_cs  = cs_q[RGN_LATCH];

endmodule
